// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter and the AXI bridge.
// Contents: requester ids, transfer size encodings, outstanding-limit bound.
package mem_req_arbiter_pkg;

  // Owner id recorded in the ordering FIFO for every accepted transaction.
  typedef enum logic {
    ID_INST = 1'b0,
    ID_DATA = 1'b1
  } req_id_e;

  // SRAM-like transfer size encoding.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Largest supported number of accepted-but-unanswered transactions.
  localparam int unsigned MAX_OUT_LIMIT = 4;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response bundle shared by the IF stage, the EXE/MEM stage
// and the memory port.
//   master : drives req, wr, size, addr, wstrb, wdata; receives addr_ok,
//            data_ok, rdata
//   slave  : the opposite direction
interface mem_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_req_arbiter_id_fifo.sv
// arb_id_fifo: ordering FIFO of 1-bit requester ids.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, push_id   enqueue push_id (ignored when full)
//   pop             dequeue head (ignored when empty)
//   head            oldest entry
//   count           number of stored entries
//   full, empty     occupancy flags
// Push and pop in the same cycle keep the count; pop always removes the
// older head, never the entry written in that cycle.
module arb_id_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  req_id_e       push_id,
  input  logic          pop,
  output req_id_e       head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  req_id_e       slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one SRAM-like memory port between the instruction
// requester and the data requester, serving requests in order and routing
// each response back to the requester that owns it.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   inst        instruction requester (read only; wr/wstrb/wdata ignored)
//   data        data requester (loads and stores)
//   mem         memory port, responses return in request order
//   arb_err     sticky: response seen with nothing outstanding
// Request and response paths are purely combinational; only the ordering
// FIFO, the grant lock and the error flag are registered.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  mem_req_arbiter_if.slave          inst,
  mem_req_arbiter_if.slave          data,
  mem_req_arbiter_if.master         mem,
  output logic                      arb_err
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  // Grant lock: remembers who was presented while memory stalled addr_ok.
  typedef enum logic [1:0] {
    LK_FREE = 2'd0,
    LK_INST = 2'd1,
    LK_DATA = 2'd2
  } lock_e;

  lock_e         lock_q;
  req_id_e       grant;
  logic          granted_req;
  logic          accept;
  logic          response;
  req_id_e       head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  always_comb begin
    unique case (lock_q)
      LK_INST: grant = ID_INST;
      LK_DATA: grant = ID_DATA;
      default: grant = data.req ? ID_DATA : ID_INST;
    endcase
  end

  always_comb begin
    mem.wr    = 1'b0;
    mem.size  = inst.size;
    mem.addr  = inst.addr;
    mem.wstrb = '0;
    mem.wdata = '0;
    granted_req = inst.req;
    if (grant == ID_DATA) begin
      mem.wr      = data.wr;
      mem.size    = data.size;
      mem.addr    = data.addr;
      mem.wstrb   = data.wstrb;
      mem.wdata   = data.wdata;
      granted_req = data.req;
    end
  end

  // Reset gates the request so nothing is accepted while state is cleared.
  assign mem.req      = granted_req & ~full & ~reset;
  assign accept       = mem.req & mem.addr_ok;
  assign inst.addr_ok = accept & (grant == ID_INST);
  assign data.addr_ok = accept & (grant == ID_DATA);

  assign response     = mem.data_ok & ~empty & ~reset;
  assign inst.data_ok = response & (head == ID_INST);
  assign data.data_ok = response & (head == ID_DATA);
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q <= LK_FREE;
    end else if (accept) begin
      lock_q <= LK_FREE;
    end else if (mem.req) begin
      lock_q <= (grant == ID_DATA) ? LK_DATA : LK_INST;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arb_err <= 1'b0;
    end else if (mem.data_ok && empty) begin
      arb_err <= 1'b1;
    end
  end

  arb_id_fifo #(
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .push_id (grant),
    .pop     (response),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  full_matches_count: assert property (
    @(posedge clk) disable iff (reset) full == (count == CW'(MAX_OUT))
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int unsigned MAX_OUT = 2;

  logic clk = 1'b0;
  logic reset;
  logic arb_err;

  mem_req_arbiter_if inst_if ();
  mem_req_arbiter_if data_if ();
  mem_req_arbiter_if mem_if ();

  mem_req_arbiter #(.MAX_OUT(MAX_OUT)) dut (
    .clk     (clk),
    .reset   (reset),
    .inst    (inst_if),
    .data    (data_if),
    .mem     (mem_if),
    .arb_err (arb_err)
  );

  always #5 clk = ~clk;

  // Reference model: queue of owners in acceptance order, presented-owner
  // memory for stalled requests, sticky error flag.
  int q[$];
  int lock_owner;
  bit m_err;
  int n_err;
  int n_checks;

  logic        obs_mem_req, obs_mem_wr, obs_arb_err;
  logic        obs_inst_addr_ok, obs_data_addr_ok;
  logic        obs_inst_data_ok, obs_data_data_ok;
  logic [31:0] obs_mem_addr, obs_inst_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    lock_owner = -1;
    m_err = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model, then return
  // 1 time unit after the rising edge so the caller can drive new inputs.
  task automatic step();
    int  owner;
    bit  full, exp_req, acc, resp;
    @(negedge clk);
    full = (q.size() >= MAX_OUT);
    if (lock_owner >= 0)   owner = lock_owner;
    else if (data_if.req)  owner = 1;
    else if (inst_if.req)  owner = 0;
    else                   owner = -1;
    exp_req = (owner == 1) ? data_if.req : (owner == 0) ? inst_if.req : 1'b0;
    exp_req = exp_req && !full;
    check("mem_req", mem_if.req, exp_req);
    if (exp_req) begin
      check("mem_addr",  mem_if.addr,  owner == 1 ? data_if.addr : inst_if.addr);
      check("mem_size",  mem_if.size,  owner == 1 ? data_if.size : inst_if.size);
      check("mem_wr",    mem_if.wr,    owner == 1 ? data_if.wr : 1'b0);
      check("mem_wstrb", mem_if.wstrb, owner == 1 ? data_if.wstrb : 4'h0);
      check("mem_wdata", mem_if.wdata, owner == 1 ? data_if.wdata : 32'h0);
    end
    acc  = exp_req && mem_if.addr_ok;
    resp = mem_if.data_ok && (q.size() > 0);
    check("inst_addr_ok", inst_if.addr_ok, acc && owner == 0);
    check("data_addr_ok", data_if.addr_ok, acc && owner == 1);
    check("inst_data_ok", inst_if.data_ok, resp && q[0] == 0);
    check("data_data_ok", data_if.data_ok, resp && q[0] == 1);
    if (resp) begin
      check("inst_rdata", inst_if.rdata, mem_if.rdata);
      check("data_rdata", data_if.rdata, mem_if.rdata);
    end
    check("arb_err", arb_err, m_err);

    obs_mem_req      = mem_if.req;
    obs_mem_wr       = mem_if.wr;
    obs_mem_addr     = mem_if.addr;
    obs_arb_err      = arb_err;
    obs_inst_addr_ok = inst_if.addr_ok;
    obs_data_addr_ok = data_if.addr_ok;
    obs_inst_data_ok = inst_if.data_ok;
    obs_data_data_ok = data_if.data_ok;
    obs_inst_rdata   = inst_if.rdata;

    if (mem_if.data_ok && q.size() == 0) m_err = 1'b1;
    if (resp) void'(q.pop_front());
    if (acc) q.push_back(owner);
    if (acc)          lock_owner = -1;
    else if (exp_req) lock_owner = owner;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = SZ_W;
    inst_if.addr = '0; inst_if.wstrb = '0; inst_if.wdata = '0;
    data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = SZ_W;
    data_if.addr = '0; data_if.wstrb = '0; data_if.wdata = '0;
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = '0;
  endtask

  task automatic drain();
    mem_if.addr_ok = 1'b0;
    for (int i = 0; i < 8 && q.size() > 0; i++) begin
      mem_if.data_ok = 1'b1;
      mem_if.rdata   = $urandom;
      step();
    end
    mem_if.data_ok = 1'b0;
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    model_reset();
    idle_inputs();
    reset = 1'b1;
    inst_if.req = 1'b1;
    mem_if.addr_ok = 1'b1;
    #2;
    check("reset_mem_req", mem_if.req, 1'b0);
    check("reset_inst_addr_ok", inst_if.addr_ok, 1'b0);
    check("reset_arb_err", arb_err, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b0;
    step();

    // Single instruction read
    inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0000; inst_if.size = SZ_W;
    step();
    mem_if.addr_ok = 1'b1;
    step();
    check("t1_inst_addr_ok", obs_inst_addr_ok, 1'b1);
    inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    step();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h0280_0000;
    step();
    check("t1_inst_data_ok", obs_inst_data_ok, 1'b1);
    check("t1_inst_rdata", obs_inst_rdata, 32'h0280_0000);
    check("t1_data_data_ok", obs_data_data_ok, 1'b0);
    mem_if.data_ok = 1'b0;

    // Contention: data store beats the instruction fetch
    inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0004;
    data_if.req = 1'b1; data_if.wr = 1'b1; data_if.addr = 32'h0000_1000;
    data_if.wstrb = 4'hF; data_if.wdata = 32'hA5A5_0001; data_if.size = SZ_W;
    mem_if.addr_ok = 1'b1;
    step();
    check("t2_data_first", obs_data_addr_ok, 1'b1);
    check("t2_mem_wr", obs_mem_wr, 1'b1);
    data_if.req = 1'b0;
    step();
    check("t2_inst_second", obs_inst_addr_ok, 1'b1);
    inst_if.req = 1'b0;
    drain();

    // Lock: stalled inst request keeps the port while data rises
    inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0040;
    mem_if.addr_ok = 1'b0;
    step();
    data_if.req = 1'b1; data_if.wr = 1'b0; data_if.addr = 32'h0000_2000;
    step();
    step();
    check("t3_lock_addr", obs_mem_addr, 32'h1c00_0040);
    mem_if.addr_ok = 1'b1;
    step();
    check("t3_inst_accept", obs_inst_addr_ok, 1'b1);
    inst_if.req = 1'b0;
    step();
    check("t3_data_accept", obs_data_addr_ok, 1'b1);
    check("t3_data_addr", obs_mem_addr, 32'h0000_2000);
    data_if.req = 1'b0;
    drain();

    // Full: third request held off until a response frees a slot
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_0100; mem_if.addr_ok = 1'b1;
    step();
    inst_if.addr = 32'h0000_0104;
    step();
    inst_if.addr = 32'h0000_0108;
    step();
    check("t4_full_mem_req", obs_mem_req, 1'b0);
    check("t4_full_addr_ok", obs_inst_addr_ok, 1'b0);
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h1111_2222;
    step();
    mem_if.data_ok = 1'b0;
    step();
    check("t4_after_pop_accept", obs_inst_addr_ok, 1'b1);
    inst_if.req = 1'b0;
    drain();

    // Simultaneous push and pop at one outstanding
    data_if.req = 1'b1; data_if.wr = 1'b0; data_if.addr = 32'h0000_3000; mem_if.addr_ok = 1'b1;
    step();
    data_if.req = 1'b0;
    inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0080;
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h3333_4444;
    step();
    check("t5_pop_older", obs_data_data_ok, 1'b1);
    check("t5_push", obs_inst_addr_ok, 1'b1);
    check("t5_not_new", obs_inst_data_ok, 1'b0);
    inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    step();
    check("t5_second_owner", obs_inst_data_ok, 1'b1);
    mem_if.data_ok = 1'b0;
    step();

    // Stray response sets the sticky error
    mem_if.data_ok = 1'b1;
    step();
    check("t6_stray_no_ok", obs_inst_data_ok | obs_data_data_ok, 1'b0);
    mem_if.data_ok = 1'b0;
    step();
    check("t6_err_set", obs_arb_err, 1'b1);
    repeat (3) step();
    check("t6_err_sticky", obs_arb_err, 1'b1);

    // Reset mid-stream with two outstanding and a held request
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_0200; mem_if.addr_ok = 1'b1;
    step();
    step();
    reset = 1'b1;
    #1;
    check("t7_rst_mem_req", mem_if.req, 1'b0);
    check("t7_rst_addr_ok", inst_if.addr_ok, 1'b0);
    check("t7_rst_arb_err", arb_err, 1'b0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    check("t7_count_cleared", obs_inst_addr_ok, 1'b1);
    inst_if.req = 1'b0;

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (inst_if.req && obs_inst_addr_ok) inst_if.req = 1'b0;
      else if (!inst_if.req && ($urandom % 3 == 0)) begin
        inst_if.req  = 1'b1;
        inst_if.addr = {$urandom} & 32'hFFFF_FFFC;
        inst_if.size = SZ_W;
      end
      if (data_if.req && obs_data_addr_ok) data_if.req = 1'b0;
      else if (!data_if.req && ($urandom % 3 == 0)) begin
        data_if.req   = 1'b1;
        data_if.wr    = 1'($urandom);
        data_if.size  = 2'($urandom_range(0, 2));
        data_if.addr  = $urandom;
        data_if.wstrb = 4'($urandom);
        data_if.wdata = $urandom;
      end
      mem_if.addr_ok = 1'($urandom);
      mem_if.data_ok = (q.size() > 0) && ($urandom % 5 < 2);
      mem_if.rdata   = $urandom;
      step();
    end
    idle_inputs();
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
